// File: rtl/sprite_anim_ctrl.sv
// Sprite frame sequencer: timebase-driven frame advance, committed only at vsync,
// plus a ROM-latency-aligned pixel mux with a hit-colour override.
module sprite_anim_ctrl #(
  parameter int NUM_FRAMES = 4,
  parameter int PIX_W      = 12,
  parameter int TICK_DIV   = 6000000,
  parameter int HOLD_TICKS = 4,
  parameter int ROM_LAT    = 1,
  parameter logic [PIX_W-1:0] HIT_COLOR = 12'h428,
  localparam int IDX_W     = $clog2(NUM_FRAMES) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic                        start,
  input  logic                        vsync_start,
  input  logic                        hit,
  input  logic [NUM_FRAMES*PIX_W-1:0] frame_pix,
  output logic [PIX_W-1:0]            vga_pix,
  output logic [IDX_W-1:0]            frame_idx,
  output logic                        done
);

  localparam int TCW = $clog2(TICK_DIV + 1);
  localparam int HCW = $clog2(HOLD_TICKS + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FRAMES - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  logic [TCW-1:0]   r_tick_cnt;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_pending;
  logic [IDX_W-1:0] r_frame_idx;
  logic             r_dir_dn;
  logic             r_done;
  logic [PIX_W-1:0] r_vga_pix;

  logic             w_tick_wrap, w_hold_wrap, w_swap;
  logic [IDX_W-1:0] w_nxt_idx;
  logic             w_nxt_dir, w_nxt_done;
  logic [IDX_W-1:0] w_idx_d;
  logic             w_hit_d;
  logic [PIX_W-1:0] w_sel_pix;

  assign w_tick_wrap = en && (r_tick_cnt == TCW'(TICK_DIV - 1));
  assign w_hold_wrap = w_tick_wrap && (r_hold_cnt == HCW'(HOLD_TICKS - 1));
  // Swaps are held off while paused so the pending flag stays frozen with the timebase.
  assign w_swap      = en && vsync_start && r_pending;

  always_comb begin
    w_nxt_idx  = r_frame_idx;
    w_nxt_dir  = r_dir_dn;
    w_nxt_done = r_done;
    case (mode)
      2'd0: w_nxt_idx = (r_frame_idx >= LAST) ? '0 : r_frame_idx + ONE;
      2'd1: begin
        if (NUM_FRAMES > 1) begin
          if (!r_dir_dn) begin
            if (r_frame_idx >= LAST) begin
              w_nxt_idx = LAST - ONE;
              w_nxt_dir = 1'b1;
            end else begin
              w_nxt_idx = r_frame_idx + ONE;
            end
          end else begin
            if (r_frame_idx == '0) begin
              w_nxt_idx = ONE;
              w_nxt_dir = 1'b0;
            end else begin
              w_nxt_idx = r_frame_idx - ONE;
            end
          end
        end
      end
      2'd2: begin
        if (!r_done) begin
          if (r_frame_idx >= LAST) begin
            w_nxt_done = 1'b1;
          end else begin
            w_nxt_idx  = r_frame_idx + ONE;
            w_nxt_done = ((r_frame_idx + ONE) == LAST);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_pending   <= 1'b0;
      r_frame_idx <= '0;
      r_dir_dn    <= 1'b0;
      r_done      <= 1'b0;
    end else if (start) begin
      r_tick_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_pending   <= 1'b0;
      r_frame_idx <= '0;
      r_dir_dn    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (en)          r_tick_cnt <= w_tick_wrap ? '0 : r_tick_cnt + TCW'(1);
      if (w_tick_wrap) r_hold_cnt <= w_hold_wrap ? '0 : r_hold_cnt + HCW'(1);
      r_pending <= (r_pending && !w_swap) || w_hold_wrap;
      if (w_swap) begin
        r_frame_idx <= w_nxt_idx;
        r_dir_dn    <= w_nxt_dir;
        r_done      <= w_nxt_done;
      end
    end
  end

  // Index and hit travel alongside the ROM read so each pixel uses the frame it was addressed with.
  generate
    if (ROM_LAT == 0) begin : g_nolat
      assign w_idx_d = r_frame_idx;
      assign w_hit_d = hit;
    end else begin : g_lat
      logic [ROM_LAT-1:0][IDX_W-1:0] r_idx_pipe;
      logic [ROM_LAT-1:0]            r_hit_pipe;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_idx_pipe <= '0;
          r_hit_pipe <= '0;
        end else begin
          r_idx_pipe[0] <= r_frame_idx;
          r_hit_pipe[0] <= hit;
          for (int i = 1; i < ROM_LAT; i++) begin
            r_idx_pipe[i] <= r_idx_pipe[i-1];
            r_hit_pipe[i] <= r_hit_pipe[i-1];
          end
        end
      end
      assign w_idx_d = r_idx_pipe[ROM_LAT-1];
      assign w_hit_d = r_hit_pipe[ROM_LAT-1];
    end
  endgenerate

  always_comb begin
    w_sel_pix = '0;
    for (int k = 0; k < NUM_FRAMES; k++)
      if (w_idx_d == IDX_W'(k)) w_sel_pix = frame_pix[k*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_vga_pix <= '0;
    else        r_vga_pix <= w_hit_d ? HIT_COLOR : w_sel_pix;
  end

  assign vga_pix   = r_vga_pix;
  assign frame_idx = r_frame_idx;
  assign done      = r_done;

endmodule
